bin2bcd_seq: RTL

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble), one bit per clock. Sits directly upstream of the per-digit BCD-to-7-segment decoders on the board display path. It takes an unsigned binary value, such as a register or ALU result, and produces DIGITS packed 4-bit BCD digits. Each digit drives one decoder instance. Codes 4'hA–4'hF are never produced, except the blank code 4'hF under the configuration macro below, which the downstream decoder renders as all segments off.

---
 rtl/bin2bcd_seq_if.sv | 13 +
 rtl/bin2bcd_seq.sv | 74 +++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between a binary producer and the bin2bcd_seq converter.
interface bin2bcd_seq_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   modport master (output start, bin, input busy, done, bcd);
   modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD, one bit per clock.
// Define BIN2BCD_BLANK_EN to blank leading zero digits with 4'hF.
module bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   bin2bcd_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   if ((64'd10 ** DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_range_check
      $error("bin2bcd_seq: DIGITS too small for WIDTH");
   end
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t                state, state_nx;
   logic [WIDTH-1:0]      shreg;
   logic [4*DIGITS-1:0]   scratch, adj, scratch_nx, shown;
   logic [CW-1:0]         cnt;
   logic                  last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      last     = cnt == CW'(1);
      state_nx = state;
      state_nx = (state == IDLE) ? (bus.start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
   end
   // add-3 on every digit in parallel, then shift the next binary bit in
   always_comb begin
      adj = scratch;
      for (int k = 0; k < DIGITS; k++)
         adj[4*k+:4] = (scratch[4*k+:4] >= 4'd5) ? scratch[4*k+:4] + 4'd3 : scratch[4*k+:4];
      scratch_nx = (adj << 1) | {{(4*DIGITS-1){1'b0}}, shreg[WIDTH-1]};
   end
`ifdef BIN2BCD_BLANK_EN
   logic lead;
   always_comb begin
      shown = scratch_nx;
      lead  = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         lead = lead && (scratch_nx[4*k+:4] == 4'd0);
         if (lead) shown[4*k+:4] = 4'hF;
      end
   end
`else
   always_comb shown = scratch_nx;
`endif
   assign bus.busy = state == SHIFT;
   // the last shift lands straight in bcd so partial results never show
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shreg    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         bus.bcd  <= '0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (state == IDLE && bus.start) begin
            shreg   <= bus.bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
         end else if (state == SHIFT) begin
            shreg   <= shreg << 1;
            scratch <= scratch_nx;
            cnt     <= cnt - CW'(1);
            if (last) begin
               bus.bcd  <= shown;
               bus.done <= 1'b1;
            end
         end
      end
endmodule
